// File: rtl/psram_spi_responder_if.sv
// Serial PSRAM link between a controller (master) and the memory device (slave).
// Mode-0 SPI: ce active low, mosi sampled on sclk rise, miso changes after fall.
interface psram_spi_responder_if;
    logic psram_ce;
    logic psram_sclk;
    logic psram_mosi;
    logic psram_miso;
    logic psram_miso_oe;

    modport master (
        output psram_ce,
        output psram_sclk,
        output psram_mosi,
        input  psram_miso,
        input  psram_miso_oe
    );

    modport slave (
        input  psram_ce,
        input  psram_sclk,
        input  psram_mosi,
        output psram_miso,
        output psram_miso_oe
    );
endinterface

// File: rtl/psram_spi_responder.sv
// Device-side PSRAM model: serves 1-bit SPI commands from a byte array,
// oversampling ce/sclk/mosi in clk_mem; backdoor port preloads and inspects memory.
module psram_spi_responder #(
    parameter int          ADDR_W = 12,
    parameter int          PAGE_W = 10,
    parameter logic [7:0]  MFID   = 8'h0D,
    parameter logic [7:0]  KGD    = 8'h5D
) (
    input  logic              clk_mem,
    input  logic              rst,
    psram_spi_responder_if.slave spi,
    output logic              busy,
    output logic              cmd_err,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_a,
    input  logic [7:0]        bd_d,
    output logic [7:0]        bd_q
);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;

    localparam logic [PAGE_W-1:0] PAGE_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_ID,
        S_IGNORE
    } state_t;

    logic [7:0] mem [2**ADDR_W];

    logic ce_s1_q, ce_s2_q, ce_d1_q;
    logic sclk_s1_q, sclk_s2_q, sclk_d1_q;
    logic mosi_s1_q, mosi_s2_q;
    logic rise_q, fall_q, mosi_q;

    state_t            state_q, state_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        opc_q, opc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idcnt_q, idcnt_d;
    logic              rst_en_q, rst_en_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic [7:0]        bd_q_q;

    logic              mem_we;
    logic [7:0]        mem_wd;
    logic [7:0]        shin;
    logic [7:0]        rdbyte;
    logic [ADDR_W-1:0] addr_inc;
    logic              ce_fall;

    // Edges are registered so miso lands 4 clk_mem after the physical fall;
    // ce flops reset low so a ce held low across reset is not seen as a new fall.
    always_ff @(posedge clk_mem) begin
        if (rst) begin
            ce_s1_q   <= 1'b0;
            ce_s2_q   <= 1'b0;
            ce_d1_q   <= 1'b0;
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_d1_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            ce_s1_q   <= spi.psram_ce;
            ce_s2_q   <= ce_s1_q;
            ce_d1_q   <= ce_s2_q;
            sclk_s1_q <= spi.psram_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_d1_q <= sclk_s2_q;
            mosi_s1_q <= spi.psram_mosi;
            mosi_s2_q <= mosi_s1_q;
            rise_q    <= sclk_s2_q & ~sclk_d1_q;
            fall_q    <= ~sclk_s2_q & sclk_d1_q;
            mosi_q    <= mosi_s2_q;
        end
    end

    assign ce_fall  = ce_d1_q & ~ce_s2_q;
    assign shin     = {shreg_q[6:0], mosi_q};
    assign addr_inc = {addr_q[ADDR_W-1:PAGE_W],
                       addr_q[PAGE_W-1:0] + PAGE_ONE};

    always_comb begin
        rdbyte = mem[addr_q];
        if (state_q == S_ID) begin
            unique case (1'b1)
                idcnt_q == 2'd0: rdbyte = MFID;
                idcnt_q == 2'd1: rdbyte = KGD;
                default:         rdbyte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        opc_d    = opc_q;
        addr_d   = addr_q;
        idcnt_d  = idcnt_q;
        rst_en_d = rst_en_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        mem_wd   = shin;

        if (ce_s2_q) begin
            state_d  = S_IDLE;
            bitcnt_d = '0;
            oe_d     = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ce_fall) begin
                        state_d  = S_CMD;
                        bitcnt_d = '0;
                    end
                end
                S_CMD: begin
                    if (rise_q) begin
                        shreg_d  = shin;
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_d = '0;
                            opc_d    = shin;
                            rst_en_d = 1'b0;
                            state_d  = S_IGNORE;
                            unique case (1'b1)
                                shin == OP_READ,
                                shin == OP_FREAD,
                                shin == OP_WRITE,
                                shin == OP_RDID: begin
                                    state_d = S_ADDR;
                                end
                                shin == OP_RSTEN: begin
                                    rst_en_d = 1'b1;
                                end
                                shin == OP_RST && rst_en_q: begin
                                    shreg_d = '0;
                                    opc_d   = '0;
                                    addr_d  = '0;
                                    idcnt_d = '0;
                                    miso_d  = 1'b0;
                                    oe_d    = 1'b0;
                                end
                                default: begin
                                    err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (rise_q) begin
                        addr_d   = {addr_q[ADDR_W-2:0], mosi_q};
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd23) begin
                            bitcnt_d = '0;
                            idcnt_d  = '0;
                            unique case (1'b1)
                                opc_q == OP_READ:  state_d = S_RDATA;
                                opc_q == OP_FREAD: state_d = S_DUMMY;
                                opc_q == OP_WRITE: state_d = S_WDATA;
                                default:           state_d = S_ID;
                            endcase
                        end
                    end
                end
                S_DUMMY: begin
                    oe_d = 1'b0;
                    if (rise_q) begin
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_d = '0;
                            state_d  = S_RDATA;
                        end
                    end
                end
                S_RDATA, S_ID: begin
                    if (fall_q) begin
                        oe_d     = 1'b1;
                        bitcnt_d = (bitcnt_q == 5'd7) ? 5'd0 : bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd0) begin
                            miso_d  = rdbyte[7];
                            shreg_d = {rdbyte[6:0], 1'b0};
                            if (state_q == S_RDATA) begin
                                addr_d = addr_inc;
                            end else if (idcnt_q != 2'd2) begin
                                idcnt_d = idcnt_q + 2'd1;
                            end
                        end else begin
                            miso_d  = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
                S_WDATA: begin
                    if (rise_q) begin
                        shreg_d  = shin;
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            mem_we   = 1'b1;
                            addr_d   = addr_inc;
                            bitcnt_d = '0;
                        end
                    end
                end
                S_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            opc_q    <= '0;
            addr_q   <= '0;
            idcnt_q  <= '0;
            rst_en_q <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            opc_q    <= opc_d;
            addr_q   <= addr_d;
            idcnt_q  <= idcnt_d;
            rst_en_q <= rst_en_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            err_q    <= err_d;
        end
    end

    // SPI write is issued last so it wins a same-byte collision with the backdoor.
    always_ff @(posedge clk_mem) begin
        if (bd_we) begin
            mem[bd_a] <= bd_d;
        end
        if (mem_we) begin
            mem[addr_q] <= mem_wd;
        end
    end

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            bd_q_q <= '0;
        end else begin
            bd_q_q <= mem[bd_a];
        end
    end

    assign bd_q              = bd_q_q;
    assign busy              = (state_q != S_IDLE);
    assign cmd_err           = err_q;
    assign spi.psram_miso    = miso_q;
    assign spi.psram_miso_oe = oe_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
// Directed bench for psram_spi_responder: a byte-array model predicts every
// read bit, oe and busy level; a compare process checks them each bit window.
module tb_psram_spi_responder;

    logic        clk_mem = 1'b0;
    logic        rst;
    logic        busy;
    logic        cmd_err;
    logic        bd_we;
    logic [11:0] bd_a;
    logic [7:0]  bd_d;
    logic [7:0]  bd_q;

    always #5 clk_mem = ~clk_mem;

    psram_spi_responder_if spi ();

    psram_spi_responder dut (
        .clk_mem (clk_mem),
        .rst     (rst),
        .spi     (spi),
        .busy    (busy),
        .cmd_err (cmd_err),
        .bd_we   (bd_we),
        .bd_a    (bd_a),
        .bd_d    (bd_d),
        .bd_q    (bd_q)
    );

    int   tests      = 0;
    int   fails      = 0;
    int   err_pulses = 0;
    logic chk_en     = 1'b0;
    logic exp_oe     = 1'b0;
    logic exp_miso   = 1'b0;
    logic exp_busy   = 1'b1;

    logic [7:0] mem_m [4096];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst address: upper bits fixed, low 10 bits wrap within the page.
    function automatic logic [11:0] m_addr(input logic [23:0] a, input int i);
        int base;
        base = int'(a[11:0]);
        return 12'((base & 'hC00) | ((base + i) & 'h3FF));
    endfunction

    function automatic logic [7:0] m_id(input int i);
        if (i == 0) return 8'h0D;
        if (i == 1) return 8'h5D;
        return 8'h00;
    endfunction

    initial begin
        forever begin
            @(negedge clk_mem);
            #1;
            if (cmd_err === 1'b1) err_pulses++;
            if (chk_en) begin
                check("oe", {31'd0, spi.psram_miso_oe}, {31'd0, exp_oe});
                check("busy", {31'd0, busy}, {31'd0, exp_busy});
                if (exp_oe) begin
                    check("miso", {31'd0, spi.psram_miso}, {31'd0, exp_miso});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // One sclk period (8 low + 8 high); outputs are judged late in the low half.
    task automatic spi_bit(input logic mo, input logic e_oe, input logic e_miso);
        spi.psram_sclk = 1'b0;
        spi.psram_mosi = mo;
        repeat (4) @(negedge clk_mem);
        exp_oe   = e_oe;
        exp_miso = e_miso;
        chk_en   = 1'b1;
        repeat (3) @(negedge clk_mem);
        chk_en = 1'b0;
        @(negedge clk_mem);
        spi.psram_sclk = 1'b1;
        repeat (8) @(negedge clk_mem);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i], 1'b0, 1'b0);
    endtask

    task automatic recv_byte(input logic [7:0] e);
        for (int i = 7; i >= 0; i--) spi_bit(1'b0, 1'b1, e[i]);
    endtask

    task automatic begin_xfer();
        spi.psram_sclk = 1'b0;
        spi.psram_ce   = 1'b0;
        repeat (4) @(negedge clk_mem);
    endtask

    task automatic end_xfer();
        spi.psram_sclk = 1'b0;
        repeat (4) @(negedge clk_mem);
        spi.psram_ce = 1'b1;
        repeat (6) @(negedge clk_mem);
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
        begin_xfer();
        send_byte(op);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic spi_write2(input logic [23:0] a, input logic [7:0] d0,
                              input logic [7:0] d1);
        cmd_addr(8'h02, a);
        send_byte(d0);
        mem_m[m_addr(a, 0)] = d0;
        send_byte(d1);
        mem_m[m_addr(a, 1)] = d1;
        end_xfer();
    endtask

    task automatic spi_read(input logic [7:0] op, input logic [23:0] a,
                            input int n);
        cmd_addr(op, a);
        if (op == 8'h0B) send_byte(8'h00);
        for (int i = 0; i < n; i++) begin
            if (op == 8'h9F) recv_byte(m_id(i));
            else recv_byte(mem_m[m_addr(a, i)]);
        end
        end_xfer();
    endtask

    task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
        bd_a  = a;
        bd_d  = d;
        bd_we = 1'b1;
        @(negedge clk_mem);
        bd_we    = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic bd_check(input string name, input logic [11:0] a,
                            input logic [7:0] e);
        bd_a = a;
        repeat (2) @(negedge clk_mem);
        check(name, {24'd0, bd_q}, {24'd0, e});
    endtask

    initial begin
        int e0;
        spi.psram_ce   = 1'b1;
        spi.psram_sclk = 1'b0;
        spi.psram_mosi = 1'b0;
        rst   = 1'b1;
        bd_we = 1'b0;
        bd_a  = '0;
        bd_d  = '0;
        repeat (4) @(negedge clk_mem);
        check("rst_miso", {31'd0, spi.psram_miso}, 32'd0);
        check("rst_oe", {31'd0, spi.psram_miso_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_bd_q", {24'd0, bd_q}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_mem);

        spi_write2(24'h000010, 8'hA5, 8'h5A);
        spi_read(8'h03, 24'h000010, 2);
        bd_check("t1_bd010", 12'h010, 8'hA5);
        bd_check("t1_bd011", 12'h011, 8'h5A);

        bd_write(12'h020, 8'h11);
        bd_write(12'h021, 8'h22);
        bd_write(12'h022, 8'h33);
        bd_write(12'h023, 8'h44);
        spi_read(8'h0B, 24'h000020, 4);

        bd_write(12'h400, 8'h77);
        spi_write2(24'h0003FF, 8'hC3, 8'h3C);
        bd_check("t3_bd3ff", 12'h3FF, 8'hC3);
        bd_check("t3_bd000", 12'h000, 8'h3C);
        bd_check("t3_bd400", 12'h400, 8'h77);
        spi_read(8'h03, 24'h0003FF, 2);

        bd_write(12'h040, 8'hE7);
        cmd_addr(8'h02, 24'h000040);
        spi_bit(1'b0, 1'b0, 1'b0);
        spi_bit(1'b1, 1'b0, 1'b0);
        spi_bit(1'b0, 1'b0, 1'b0);
        spi_bit(1'b1, 1'b0, 1'b0);
        spi.psram_sclk = 1'b0;
        repeat (2) @(negedge clk_mem);
        check("t4_busy_before", {31'd0, busy}, 32'd1);
        spi.psram_ce = 1'b1;
        repeat (3) @(negedge clk_mem);
        check("t4_busy_after", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk_mem);
        bd_check("t4_bd040", 12'h040, 8'hE7);

        e0 = err_pulses;
        begin_xfer();
        send_byte(8'hAB);
        send_byte(8'hFF);
        end_xfer();
        check("t5_err_ab", err_pulses - e0, 32'd1);
        e0 = err_pulses;
        begin_xfer();
        send_byte(8'h99);
        end_xfer();
        check("t5_err_99", err_pulses - e0, 32'd1);
        e0 = err_pulses;
        begin_xfer();
        send_byte(8'h66);
        end_xfer();
        begin_xfer();
        send_byte(8'h99);
        send_byte(8'h00);
        end_xfer();
        check("t5_err_66_99", err_pulses - e0, 32'd0);
        spi_read(8'h03, 24'h000010, 1);

        cmd_addr(8'h9F, 24'h000000);
        for (int i = 0; i < 3; i++) recv_byte(m_id(i));
        spi.psram_sclk = 1'b0;
        repeat (2) @(negedge clk_mem);
        check("t6_oe_pre", {31'd0, spi.psram_miso_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk_mem);
        rst = 1'b0;
        check("t6_oe_rst", {31'd0, spi.psram_miso_oe}, 32'd0);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        exp_busy = 1'b0;
        send_byte(8'h03);
        exp_busy = 1'b1;
        end_xfer();
        spi_read(8'h03, 24'h000020, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
